// File: rtl/double_to_sig16b_pkg.sv
// ---------------------------------------------------------------------------
// double_to_sig16b_pkg
// Shared constants and types for the binary64 -> int16 sample converter.
// No ports. Holds the IEEE-754 field layout, saturation limits and the
// intermediate record carried between the align and round pipeline stages.
// ---------------------------------------------------------------------------
package double_to_sig16b_pkg;

   localparam int SIGN_W   = 1;
   localparam int EXP_W    = 11;
   localparam int FRAC_W   = 52;
   localparam int CNT_W    = 13;
   localparam int RES_W    = 16;

   // Aligned magnitude = integer part (16 bits) plus one round bit.
   localparam int ALIGN_W  = 17;

   localparam logic [EXP_W-1:0] EXP_BIAS = 11'd1023;
   localparam logic [EXP_W-1:0] EXP_MAX  = 11'd2047;

   localparam logic [RES_W-1:0] SAT_POS  = 16'h7FFF;
   localparam logic [RES_W-1:0] SAT_NEG  = 16'h8000;

   typedef struct packed {
      logic [SIGN_W-1:0] sign;
      logic [EXP_W-1:0]  exp;
      logic [FRAC_W-1:0] frac;
   } f64_t;

   // Classification decided in the align stage so the round stage only
   // needs to look at this tag plus the aligned bits.
   typedef enum logic [2:0] {
      K_ZERO = 3'd0,   // zero / subnormal
      K_NAN  = 3'd1,
      K_INF  = 3'd2,
      K_OVF  = 3'd3,   // finite, exponent >= 16
      K_NORM = 3'd4
   } kind_t;

   typedef struct packed {
      logic               sign;
      kind_t              kind;
      logic [ALIGN_W-1:0] aligned;
   } align_t;

endpackage

// File: rtl/double_to_sig16b_if.sv
// ---------------------------------------------------------------------------
// double_to_sig16b_if
// Sample bus between the sample source and the converter.
//   enable                 : pipeline advance / output update qualifier
//   double                 : binary64 sample, 1.0 = one LSB
//   sampling_cycle_counter : 0 marks the output-update slot
//   sig16b                 : registered two's-complement result
// master = sample source, slave = converter.
// ---------------------------------------------------------------------------
interface double_to_sig16b_if;
   import double_to_sig16b_pkg::*;

   logic             enable;
   logic [63:0]      double;
   logic [CNT_W-1:0] sampling_cycle_counter;
   logic [RES_W-1:0] sig16b;

   modport master (
      output enable, double, sampling_cycle_counter,
      input  sig16b
   );

   modport slave (
      input  enable, double, sampling_cycle_counter,
      output sig16b
   );

endinterface

// File: rtl/double_to_sig16b_f64_to_int16_sat.sv
// ---------------------------------------------------------------------------
// f64_to_int16_sat
// Purely combinational binary64 -> saturated int16 conversion, exposed as
// two independent halves so the caller can place a register between them.
//   i_double  -> o_align  : unpack, classify, align magnitude (+ round bit)
//   i_align   -> o_result : round half away from zero, saturate, apply sign
// ---------------------------------------------------------------------------
module f64_to_int16_sat
   import double_to_sig16b_pkg::*;
(
   input  f64_t             i_double,
   output align_t           o_align,
   input  align_t           i_align,
   output logic [RES_W-1:0] o_result
);

   // ---------------- align half ----------------
   logic signed [EXP_W:0] w_e;        // unbiased exponent
   logic [FRAC_W:0]       w_mant;     // 1.F
   logic [5:0]            w_shamt;
   logic [ALIGN_W-1:0]    w_shifted;

   assign w_e     = $signed({1'b0, i_double.exp}) - $signed({1'b0, EXP_BIAS});
   assign w_mant  = {1'b1, i_double.frac};
   // Keep the integer bits plus the first discarded bit: for 0 <= e <= 15
   // this is (1.F * 2^e) * 2 truncated, so bit 0 is the round bit.
   assign w_shamt   = 6'd51 - w_e[5:0];
   assign w_shifted = ALIGN_W'(w_mant >> w_shamt);

   always_comb begin
      o_align      = '0;
      o_align.sign = i_double.sign[0];
      o_align.kind = K_NORM;
      if (i_double.exp == '0) begin
         o_align.kind = K_ZERO;
      end else if (i_double.exp == EXP_MAX) begin
         o_align.kind = (i_double.frac != '0) ? K_NAN : K_INF;
      end else if (w_e >= 12'sd16) begin
         // Too large for any shift to matter; tagged for saturation.
         o_align.kind = K_OVF;
      end else if (w_e >= 12'sd0) begin
         o_align.aligned = w_shifted;
      end else if (w_e == -12'sd1) begin
         // 0.5 <= |x| < 1: integer 0 with round bit set -> rounds to 1.
         o_align.aligned = ALIGN_W'(1);
      end
      // e <= -2 leaves aligned = 0
   end

   // ---------------- round / saturate half ----------------
   logic [ALIGN_W:0] w_m;             // rounded magnitude, up to 65536

   assign w_m = ({1'b0, i_align.aligned} + (ALIGN_W+1)'(1)) >> 1;

   always_comb begin
      o_result = '0;
      case (i_align.kind)
         K_INF, K_OVF: begin
            o_result = i_align.sign ? SAT_NEG : SAT_POS;
         end
         K_NORM: begin
            if (w_m >= (ALIGN_W+1)'(32768))
               o_result = i_align.sign ? SAT_NEG : SAT_POS;
            else if (i_align.sign)
               o_result = -w_m[RES_W-1:0];
            else
               o_result = w_m[RES_W-1:0];
         end
         default: o_result = '0;   // zero, subnormal, NaN
      endcase
   end

endmodule

// File: rtl/double_to_sig16b.sv
// ---------------------------------------------------------------------------
// double_to_sig16b
// Three-stage binary64 -> int16 sample converter with slot-gated output.
//   clk_operation : sole clock
//   rst           : synchronous active-high reset, clears every register
//   bus (slave)   : enable, double, sampling_cycle_counter in; sig16b out
// Stages (advance only while enable=1):
//   S1 capture raw double, S2 aligned magnitude, S3 rounded result R.
// sig16b takes R on enabled edges where the counter is 0, so a sample
// arriving on that same edge is seen only on a later update slot.
// ---------------------------------------------------------------------------
module double_to_sig16b
   import double_to_sig16b_pkg::*;
(
   input  logic              clk_operation,
   input  logic              rst,
   double_to_sig16b_if.slave bus
);

   f64_t             r_s1;
   align_t           r_s2;
   logic [RES_W-1:0] r_result;
   logic [RES_W-1:0] r_sig16b;

   align_t           w_align;
   logic [RES_W-1:0] w_result;
   logic             w_slot;

   assign w_slot = (bus.sampling_cycle_counter == '0);

   f64_to_int16_sat u_conv (
      .i_double (r_s1),
      .o_align  (w_align),
      .i_align  (r_s2),
      .o_result (w_result)
   );

   always_ff @(posedge clk_operation) begin
      if (rst) begin
         r_s1     <= '0;
         r_s2     <= '0;
         r_result <= '0;
         r_sig16b <= '0;
      end else if (bus.enable) begin
         r_s1     <= bus.double;
         r_s2     <= w_align;
         r_result <= w_result;
         if (w_slot)
            r_sig16b <= r_result;   // old R, before this edge's update
      end
   end

   assign bus.sig16b = r_sig16b;

endmodule

// File: tb/tb_double_to_sig16b.sv
module tb_double_to_sig16b;
   import double_to_sig16b_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   double_to_sig16b_if bus ();

   double_to_sig16b dut (
      .clk_operation (clk),
      .rst           (rst),
      .bus           (bus)
   );

   int   n_chk  = 0;
   int   n_pass = 0;
   bit   chk_en = 1'b0;

   logic [15:0] exp_sig = 16'h0;
   logic [15:0] conv_q[$];          // converted enabled samples, newest first

   logic [63:0] specials [8] = '{
      64'h7FF0000000000000, 64'hFFF0000000000000, 64'h7FF8000000000000,
      64'h8000000000000000, 64'h0000000000000001, 64'h40DFFFE000000000,
      64'hC0DFFFE000000000, 64'h40DFFFC000000000
   };

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] expv);
      n_chk++;
      if (act === expv) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
   endtask

   // Reference: value semantics straight from the rules, using real math.
   function automatic logic [15:0] ref_conv(input logic [63:0] b);
      logic [10:0] e;
      real a;
      real fl;
      int  m;
      e = b[62:52];
      if (e == 11'd0) return 16'h0000;
      if (e == 11'd2047) begin
         if (b[51:0] != 52'd0) return 16'h0000;
         return b[63] ? 16'h8000 : 16'h7FFF;
      end
      a = $bitstoreal(b);
      if (a < 0.0) a = -a;
      if (a >= 32768.0) m = 32768;
      else begin
         fl = $floor(a);
         m  = int'(fl);
         if (a - fl >= 0.5) m = m + 1;
      end
      if (b[63]) return (m >= 32768) ? 16'h8000 : 16'(-m);
      return (m >= 32768) ? 16'h7FFF : 16'(m);
   endfunction

   function automatic logic [63:0] rand_dbl();
      logic [63:0] rb;
      real r;
      rb = {$urandom(), $urandom()};
      case ($urandom_range(0, 5))
         0: begin
            r = (real'($urandom_range(0, 2000000)) - 1000000.0) / 16.0;
            rb = $realtobits(r);
         end
         1: begin
            r = (real'($urandom_range(0, 64)) - 32.0) / 16.0;
            rb = $realtobits(r);
         end
         2: rb[62:52] = 11'(1020 + $urandom_range(0, 20));
         3: rb = specials[$urandom_range(0, 7)];
         4: ;   // fully random bit pattern
         default: begin
            r = 32766.0 + real'($urandom_range(0, 12)) * 0.25;
            if ($urandom_range(0, 1) == 1) r = -r;
            rb = $realtobits(r);
         end
      endcase
      return rb;
   endfunction

   // Model: R after an enabled edge is the conversion of the sample captured
   // two enabled edges before it; sig16b takes the pre-edge R on slot edges.
   always @(posedge clk) begin
      logic [15:0] r_before;
      if (rst) begin
         conv_q.delete();
         exp_sig = 16'h0;
      end else if (bus.enable) begin
         r_before = (conv_q.size() >= 3) ? conv_q[2] : 16'h0;
         if (bus.sampling_cycle_counter == 13'd0) exp_sig = r_before;
         conv_q.push_front(ref_conv(bus.double));
         while (conv_q.size() > 3) void'(conv_q.pop_back());
      end
   end

   always @(negedge clk) begin
      if (chk_en) check("model", bus.sig16b, exp_sig);
   end

   // 3 non-slot edges fill the pipeline (output must hold), then one slot edge.
   task automatic convert(input logic [63:0] d, input logic [15:0] prev,
                          input logic [15:0] expv, input string name);
      bus.enable = 1'b1;
      bus.double = d;
      for (int k = 0; k < 3; k++) begin
         bus.sampling_cycle_counter = 13'(k + 1);
         @(negedge clk);
         check({name, "_hold"}, bus.sig16b, prev);
      end
      bus.sampling_cycle_counter = 13'd0;
      @(negedge clk);
      check(name, bus.sig16b, expv);
   endtask

   initial begin
      bus.enable = 1'b1;
      bus.double = 64'h4094000000000000;
      bus.sampling_cycle_counter = 13'd0;
      rst = 1'b1;

      check("pin_1280",  ref_conv(64'h4094000000000000), 16'h0500);
      check("pin_m2p5",  ref_conv(64'hC004000000000000), 16'hFFFD);
      check("pin_0p49",  ref_conv(64'h3FDF5C28F5C28F5C), 16'h0000);
      check("pin_m1e6",  ref_conv(64'hC12E848000000000), 16'h8000);

      repeat (3) begin
         @(negedge clk);
         check("reset_hold", bus.sig16b, 16'h0000);
      end
      chk_en = 1'b1;
      rst = 1'b0;
      @(negedge clk);
      check("post_reset_first", bus.sig16b, 16'h0000);

      convert(64'h4094000000000000, 16'h0000, 16'h0500, "exact_1280");
      convert(64'hC004000000000000, 16'h0500, 16'hFFFD, "round_m2p5");
      convert(64'h3FE0000000000000, 16'hFFFD, 16'h0001, "round_0p5");
      convert(64'h3FDF5C28F5C28F5C, 16'h0001, 16'h0000, "round_0p49");
      convert(64'h412E848000000000, 16'h0000, 16'h7FFF, "sat_pos");
      convert(64'hC12E848000000000, 16'h7FFF, 16'h8000, "sat_neg");
      convert(64'h7FF8000000000000, 16'h8000, 16'h0000, "nan");
      convert(64'hC0E0000000000000, 16'h0000, 16'h8000, "neg_32768");
      convert(64'h0000000000000000, 16'h8000, 16'h0000, "zero");
      convert(64'hFFF0000000000000, 16'h0000, 16'h8000, "neg_inf");
      convert(64'h4094000000000000, 16'h8000, 16'h0500, "exact_again");

      // Freeze: enable low across slot edges must not move output or pipeline.
      bus.double = 64'hC004000000000000;
      bus.sampling_cycle_counter = 13'd1;
      repeat (2) begin
         @(negedge clk);
         check("pre_freeze_hold", bus.sig16b, 16'h0500);
      end
      bus.enable = 1'b0;
      bus.sampling_cycle_counter = 13'd0;
      repeat (3) begin
         @(negedge clk);
         check("freeze_hold", bus.sig16b, 16'h0500);
      end
      bus.enable = 1'b1;
      @(negedge clk);
      check("freeze_pipe", bus.sig16b, 16'h0500);
      @(negedge clk);
      check("freeze_resume", bus.sig16b, 16'hFFFD);

      // Reset mid-pipeline: in-flight 1e6 must never appear.
      bus.double = 64'h412E848000000000;
      bus.sampling_cycle_counter = 13'd1;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("mid_reset", bus.sig16b, 16'h0000);
      rst = 1'b0;
      bus.double = 64'h0000000000000000;
      bus.sampling_cycle_counter = 13'd0;
      repeat (3) begin
         @(negedge clk);
         check("no_stale", bus.sig16b, 16'h0000);
      end

      // Randomized traffic, checked every cycle by the model process.
      for (int i = 0; i < 3000; i++) begin
         bus.double = rand_dbl();
         bus.enable = ($urandom_range(0, 99) < 85);
         bus.sampling_cycle_counter = 13'(i % 6);
         rst = ($urandom_range(0, 199) == 0);
         @(negedge clk);
      end
      rst = 1'b0;
      @(negedge clk);
      chk_en = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
